conv_feeder: RTL and testbench

- Streaming source that drives the load and compute interface of the binary-weight conv engine.
- On `start`, fetches TI 9-bit kernels and DATA_WORDS packed activation words from two single-port read memories (1-cycle read latency).
- Presents them with `buffer_weight_fire` / `buffer_data_fire` pulses, then issues a `compute_fire` burst of COMPUTE_CYCLES qualified cycles.
- Sits between the tile SRAMs and the conv engine.

---
 rtl/conv_feeder.sv | 149 ++++++++++++++
 tb/tb_conv_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
// Streaming feeder for the binary-weight conv engine: reads TI kernels and DATA_WORDS
// activation words from 1-cycle-latency memories, strobes them out, then runs the compute burst.
module conv_feeder #(
  parameter int TI             = 3,
  parameter int DATA_WORDS     = 48,
  parameter int COMPUTE_CYCLES = 42,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [6*TI-1:0]   act_rd_data,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic [8:0]        w_rd_data,
  output logic [6*TI-1:0]   data_out,
  output logic [8:0]        weight_out,
  output logic              buffer_data_fire,
  output logic              buffer_weight_fire,
  output logic              compute_fire,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(TI + DATA_WORDS + COMPUTE_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_D  = 3'd2,
    S_COMPUTE = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_act_base;
  logic              r_w_pend;
  logic              r_a_pend;

  assign dbg_state = r_state;

  // Handshake: no back-pressure on loads; a read issued in cycle t returns data in t+1,
  // which is registered and strobed in t+2. hold only gates compute_fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_act_base         <= '0;
      r_w_pend           <= 1'b0;
      r_a_pend           <= 1'b0;
      act_rd_en          <= 1'b0;
      act_rd_addr        <= '0;
      w_rd_en            <= 1'b0;
      w_rd_addr          <= '0;
      data_out           <= '0;
      weight_out         <= '0;
      buffer_data_fire   <= 1'b0;
      buffer_weight_fire <= 1'b0;
      compute_fire       <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      done <= 1'b0;
      // Read-return pipeline; abort kills anything still in flight.
      r_w_pend           <= w_rd_en & ~abort;
      r_a_pend           <= act_rd_en & ~abort;
      buffer_weight_fire <= r_w_pend & ~abort;
      buffer_data_fire   <= r_a_pend & ~abort;
      if (r_w_pend && !abort) weight_out <= w_rd_data;
      if (r_a_pend && !abort) data_out <= act_rd_data;

      if (abort) begin
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        w_rd_en      <= 1'b0;
        act_rd_en    <= 1'b0;
        compute_fire <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_act_base <= act_base;
              w_rd_addr  <= w_base;
              w_rd_en    <= 1'b1;
              busy       <= 1'b1;
              r_cnt      <= CNT_W'(1);
              r_state    <= S_LOAD_W;
            end
          end
          S_LOAD_W: begin
            if (r_cnt == CNT_W'(TI)) begin
              w_rd_en     <= 1'b0;
              act_rd_en   <= 1'b1;
              act_rd_addr <= r_act_base;
              r_cnt       <= CNT_W'(1);
              r_state     <= S_LOAD_D;
            end else begin
              w_rd_addr <= w_rd_addr + ADDR_W'(1);
              r_cnt     <= r_cnt + CNT_W'(1);
            end
          end
          S_LOAD_D: begin
            // Issue phase, then one drain cycle so the move to COMPUTE lands on the last fire.
            if (r_cnt < CNT_W'(DATA_WORDS)) begin
              act_rd_addr <= act_rd_addr + ADDR_W'(1);
              r_cnt       <= r_cnt + CNT_W'(1);
            end else if (r_cnt == CNT_W'(DATA_WORDS)) begin
              act_rd_en <= 1'b0;
              r_cnt     <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt   <= '0;
              r_state <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            compute_fire <= ~hold;
            if (!hold) begin
              if (r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_state <= S_FIN;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          S_FIN: begin
            compute_fire <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: planned stimulus tables, a cycle-indexed expectation model built
// from the tile timing rules, a per-cycle compare process, and literal pin checks.
module tb_conv_feeder;
  localparam int TI = 3, DW = 48, CC = 42, AW = 12, N = 1024, BIG = 100000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [AW-1:0] act_base = '0, w_base = '0;
  logic          act_rd_en, w_rd_en;
  logic [AW-1:0] act_rd_addr, w_rd_addr;
  logic [17:0]   act_rd_data = '0;
  logic [8:0]    w_rd_data = '0;
  logic [17:0]   data_out;
  logic [8:0]    weight_out;
  logic          buffer_data_fire, buffer_weight_fire, compute_fire, busy, done;
  logic [2:0]    dbg_state;

  conv_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .act_base(act_base), .w_base(w_base),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .data_out(data_out), .weight_out(weight_out),
    .buffer_data_fire(buffer_data_fire), .buffer_weight_fire(buffer_weight_fire),
    .compute_fire(compute_fire), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock / edge counter: edge k is the posedge after which cyc == k.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as address functions; 1-cycle read latency.
  function automatic logic [8:0] wmem(logic [AW-1:0] a);
    int v;
    v = int'(a) * 7 + 3;
    return v[8:0];
  endfunction
  function automatic logic [17:0] amem(logic [AW-1:0] a);
    int v;
    v = int'(a) * 13 + 5;
    return v[17:0];
  endfunction
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem(w_rd_addr);
    if (act_rd_en) act_rd_data <= amem(act_rd_addr);
  end

  // Stimulus plan (value sampled at edge k) and expected outputs (visible after edge k).
  logic          start_plan[N], abort_plan[N], hold_plan[N];
  logic [AW-1:0] wb_plan[N], ab_plan[N];
  logic          e_wen[N], e_aen[N], e_wf[N], e_df[N], e_cf[N], e_busy[N], e_done[N];
  logic [AW-1:0] e_waddr[N], e_aaddr[N];
  logic [8:0]    e_wout[N];
  logic [17:0]   e_dout[N];

  int n_checks = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One tile started at edge e; everything at or after edge `cut` is cancelled.
  task automatic plan_tile(int e, logic [AW-1:0] wb, logic [AW-1:0] ab, int cut);
    int c, n;
    logic [AW-1:0] a;
    start_plan[e] = 1'b1; wb_plan[e] = wb; ab_plan[e] = ab;
    for (int i = 0; i < TI; i++) begin
      a = wb + AW'(i);
      if (e + i < cut) begin e_wen[e+i] = 1'b1; e_waddr[e+i] = a; end
      if (e + 2 + i < cut) begin e_wf[e+2+i] = 1'b1; e_wout[e+2+i] = wmem(a); end
    end
    for (int j = 0; j < DW; j++) begin
      a = ab + AW'(j);
      if (e + TI + j < cut) begin e_aen[e+TI+j] = 1'b1; e_aaddr[e+TI+j] = a; end
      if (e + TI + 2 + j < cut) begin e_df[e+TI+2+j] = 1'b1; e_dout[e+TI+2+j] = amem(a); end
    end
    c = e + TI + DW + 2;
    n = 0;
    while (n < CC) begin
      if (!hold_plan[c]) begin
        if (c < cut) e_cf[c] = 1'b1;
        n++;
      end
      c++;
    end
    if (c < cut) e_done[c] = 1'b1;
    for (int k = e; k < c && k < cut; k++) e_busy[k] = 1'b1;
  endtask

  task automatic wait_cyc(int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Driver: apply the plan for the coming edge on each falling edge.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      n = cyc + 1;
      if (n < N) begin
        start = start_plan[n]; abort = abort_plan[n]; hold = hold_plan[n];
        w_base = wb_plan[n]; act_base = ab_plan[n];
      end
    end
  end

  // Scoreboard compare, every cycle; data/weight outputs hold their last fired value.
  initial begin
    logic [8:0]  last_w;
    logic [17:0] last_d;
    int k;
    last_w = '0; last_d = '0;
    forever begin
      @(negedge clk);
      k = cyc;
      if (k < N) begin
        if (!rst_n) begin last_w = '0; last_d = '0; end
        if (e_wf[k]) last_w = e_wout[k];
        if (e_df[k]) last_d = e_dout[k];
        chk("w_rd_en", w_rd_en, e_wen[k]);
        if (e_wen[k]) chk("w_rd_addr", w_rd_addr, e_waddr[k]);
        chk("act_rd_en", act_rd_en, e_aen[k]);
        if (e_aen[k]) chk("act_rd_addr", act_rd_addr, e_aaddr[k]);
        chk("weight_fire", buffer_weight_fire, e_wf[k]);
        chk("data_fire", buffer_data_fire, e_df[k]);
        chk("compute_fire", compute_fire, e_cf[k]);
        chk("busy", busy, e_busy[k]);
        chk("done", done, e_done[k]);
        chk("weight_out", weight_out, last_w);
        chk("data_out", data_out, last_d);
      end
    end
  end

  initial begin
    int cnt;
    for (int k = 0; k < N; k++) begin
      start_plan[k] = 0; abort_plan[k] = 0; hold_plan[k] = 0; wb_plan[k] = '0; ab_plan[k] = '0;
      e_wen[k] = 0; e_aen[k] = 0; e_wf[k] = 0; e_df[k] = 0; e_cf[k] = 0; e_busy[k] = 0; e_done[k] = 0;
      e_waddr[k] = '0; e_aaddr[k] = '0; e_wout[k] = '0; e_dout[k] = '0;
    end
    // Nominal tile, plus a start while busy that must be ignored.
    plan_tile(10, 12'h010, 12'h100, BIG);
    start_plan[30] = 1'b1; wb_plan[30] = 12'hAAA; ab_plan[30] = 12'hBBB;
    // Hold for 5 cycles after the 10th compute fire (fires from 173, 10th at 182).
    for (int k = 183; k <= 187; k++) hold_plan[k] = 1'b1;
    plan_tile(120, 12'h040, 12'h200, BIG);
    // Hold through both load phases.
    for (int k = 240; k <= 300; k++) hold_plan[k] = 1'b1;
    plan_tile(240, 12'h050, 12'h300, BIG);
    // Abort mid LOAD_D, then a wrapping tile.
    plan_tile(360, 12'h010, 12'h100, 390);
    abort_plan[390] = 1'b1;
    plan_tile(395, 12'hFFE, 12'hFF0, BIG);
    // Abort beats start.
    start_plan[500] = 1'b1; abort_plan[500] = 1'b1; wb_plan[500] = 12'h123; ab_plan[500] = 12'h456;
    // Tile cut by async reset during COMPUTE, then a fresh tile.
    plan_tile(520, 12'h020, 12'h200, 581);
    plan_tile(610, 12'h030, 12'h300, BIG);

    // Literal pins on the model itself.
    cnt = 0;
    for (int k = 10; k < 110; k++) cnt += int'(e_cf[k]);
    chk("model_cf_count_t1", cnt, 42);
    chk("model_done_t1", e_done[105], 1);
    chk("model_wout_t1", e_wout[12], 9'h073);
    chk("model_done_hold", e_done[220], 1);
    chk("model_cf_hold_gap", e_cf[185], 0);
    chk("model_done_loadhold", e_done[343], 1);

    #23 rst_n = 1'b1;

    wait_cyc(12);
    chk("pin_first_wfire", buffer_weight_fire, 1);
    chk("pin_first_wout", weight_out, 9'h073);
    wait_cyc(15);
    chk("pin_first_dfire", buffer_data_fire, 1);
    chk("pin_first_dout", data_out, 18'h00D05);
    wait_cyc(62);
    chk("pin_cf_before", compute_fire, 0);
    wait_cyc(63);
    chk("pin_cf_first", compute_fire, 1);
    wait_cyc(104);
    chk("pin_done_early", done, 0);
    chk("pin_busy_last", busy, 1);
    wait_cyc(105);
    chk("pin_done", done, 1);
    chk("pin_busy_drop", busy, 0);
    wait_cyc(220);
    chk("pin_done_hold", done, 1);
    wait_cyc(389);
    chk("pin_aen_pre_abort", act_rd_en, 1);
    wait_cyc(390);
    chk("pin_abort_aen", act_rd_en, 0);
    chk("pin_abort_busy", busy, 0);
    chk("pin_abort_dfire", buffer_data_fire, 0);
    wait_cyc(395);
    chk("pin_wrap_w0", w_rd_addr, 12'hFFE);
    wait_cyc(397);
    chk("pin_wrap_w2", w_rd_addr, 12'h000);
    wait_cyc(413);
    chk("pin_wrap_a15", act_rd_addr, 12'hFFF);
    wait_cyc(414);
    chk("pin_wrap_a16", act_rd_addr, 12'h000);
    wait_cyc(416);
    chk("pin_wrap_dout", data_out, 18'h00005);
    wait_cyc(580);
    chk("pin_cf_pre_reset", compute_fire, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("pin_rst_cf", compute_fire, 0);
    chk("pin_rst_busy", busy, 0);
    chk("pin_rst_dout", data_out, 0);
    chk("pin_rst_wout", weight_out, 0);
    chk("pin_rst_state", dbg_state, 0);
    wait_cyc(582);
    #3 rst_n = 1'b1;
    wait_cyc(705);
    chk("pin_done_after_reset", done, 1);
    wait_cyc(720);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
